// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the core program counter. Fetches one instruction per
// step over a req/ack handshake, holds it in the instruction register for the
// execute path, and loads the branch_logic next-PC when the core retires it.
// All outputs are registered; reset is asynchronous so outputs drop at once.
module fetch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [INSTR_W-1:0] mem_data_i,
    output logic [ADDR_W-1:0]  address_o,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               instr_valid_o,
    input  logic               done_i,
    input  logic [ADDR_W-1:0]  new_pc_i,
    output logic               fetch_err_o,
    output logic [15:0]        instr_count_o
);

    // Wait counter only has to reach TIMEOUT-1.
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               valid_q, valid_d;

    // Retired-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next-state and next-output computation; outputs are derived from the
    // next state so they appear registered in the cycle the state is entered.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // A timed-out fetch parks the sequencer until reset.
                if (en_i && !err_q) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Ack has priority over the timeout in the same cycle.
                if (mem_ack_i) begin
                    ir_d    = mem_data_i;
                    tmo_d   = '0;
                    state_d = ST_EXEC;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            ST_EXEC: begin
                if (done_i) begin
                    pc_d    = new_pc_i;
                    cnt_d   = sat_inc(cnt_q);
                    state_d = en_i ? ST_FETCH : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mem_req_d  = (state_d == ST_FETCH);
        mem_addr_d = mem_req_d ? pc_d : '0;
        valid_d    = (state_d == ST_EXEC);
    end

    // State and registered outputs; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign address_o     = pc_q;
    assign instruction_o = ir_q;
    assign instr_valid_o = valid_q;
    assign fetch_err_o   = err_q;
    assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by randomized
// instruction streams, checked against a transaction-level model of PC, IR,
// error flag and retired count.
module tb_fetch_sequencer;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               en_i;
    logic               mem_req_o;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic               mem_ack_i;
    logic [INSTR_W-1:0] mem_data_i;
    logic [ADDR_W-1:0]  address_o;
    logic [INSTR_W-1:0] instruction_o;
    logic               instr_valid_o;
    logic               done_i;
    logic [ADDR_W-1:0]  new_pc_i;
    logic               fetch_err_o;
    logic [15:0]        instr_count_o;

    fetch_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .en_i          (en_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_data_i    (mem_data_i),
        .address_o     (address_o),
        .instruction_o (instruction_o),
        .instr_valid_o (instr_valid_o),
        .done_i        (done_i),
        .new_pc_i      (new_pc_i),
        .fetch_err_o   (fetch_err_o),
        .instr_count_o (instr_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state only.
    logic [ADDR_W-1:0]  m_pc;
    logic [INSTR_W-1:0] m_ir;
    logic [15:0]        m_cnt;
    logic               m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model; req/valid say which phase we expect.
    task automatic check_outputs(input string tag, input logic req, input logic valid);
        check_val({tag, ".req"},   32'(mem_req_o), 32'(req));
        check_val({tag, ".maddr"}, 32'(mem_addr_o), req ? 32'(m_pc) : 32'd0);
        check_val({tag, ".addr"},  32'(address_o), 32'(m_pc));
        check_val({tag, ".instr"}, 32'(instruction_o), 32'(m_ir));
        check_val({tag, ".valid"}, 32'(instr_valid_o), 32'(valid));
        check_val({tag, ".err"},   32'(fetch_err_o), 32'(m_err));
        check_val({tag, ".count"}, 32'(instr_count_o), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: outputs must clear with no clock edge in between.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        en_i  = 1'b0;
        #1;
        m_pc = '0; m_ir = '0; m_cnt = '0; m_err = 1'b0;
        check_outputs(tag, 1'b0, 1'b0);
        tick();
        reset     = 1'b0;
        mem_ack_i = 1'b0;
        tick();
        check_outputs({tag, ".idle"}, 1'b0, 1'b0);
    endtask

    // From IDLE: raise en_i, expect the request on the next cycle.
    task automatic start_fetch(input string tag);
        en_i      = 1'b1;
        mem_ack_i = 1'b0;
        tick();
        check_outputs(tag, 1'b1, 1'b0);
    endtask

    // In FETCH: withhold ack for wait_n cycles, then ack with data.
    task automatic do_fetch(input string tag, input int wait_n, input logic [INSTR_W-1:0] data);
        for (int k = 0; k < wait_n; k++) begin
            mem_ack_i  = 1'b0;
            mem_data_i = INSTR_W'($urandom);
            done_i     = 1'($urandom);
            new_pc_i   = ADDR_W'($urandom);
            en_i       = 1'($urandom);
            tick();
            check_outputs({tag, ".wait"}, 1'b1, 1'b0);
        end
        mem_ack_i  = 1'b1;
        mem_data_i = data;
        tick();
        m_ir = data;
        check_outputs({tag, ".exec"}, 1'b0, 1'b1);
    endtask

    // In FETCH: never ack; error must appear after TIMEOUT request cycles.
    task automatic do_timeout(input string tag);
        for (int k = 0; k < TIMEOUT; k++) begin
            check_val({tag, ".req_held"}, 32'(mem_req_o), 32'd1);
            mem_ack_i = 1'b0;
            en_i      = 1'($urandom);
            tick();
        end
        m_err = 1'b1;
        check_outputs({tag, ".err"}, 1'b0, 1'b0);
        en_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_ack_i = 1'($urandom);
            tick();
            check_outputs({tag, ".parked"}, 1'b0, 1'b0);
        end
    endtask

    // In EXEC: hold for hold_n cycles with ack noise, then retire.
    task automatic do_exec(input string tag, input int hold_n, input logic en_after,
                           input logic [ADDR_W-1:0] npc);
        for (int h = 0; h < hold_n; h++) begin
            done_i     = 1'b0;
            mem_ack_i  = 1'($urandom);
            mem_data_i = INSTR_W'($urandom);
            new_pc_i   = ADDR_W'($urandom);
            en_i       = 1'($urandom);
            tick();
            check_outputs({tag, ".hold"}, 1'b0, 1'b1);
        end
        done_i   = 1'b1;
        new_pc_i = npc;
        en_i     = en_after;
        tick();
        m_pc  = npc;
        m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        check_outputs({tag, ".retire"}, en_after, 1'b0);
    endtask

    // In IDLE with en_i low: ack/done noise must change nothing.
    task automatic idle_noise(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            en_i      = 1'b0;
            mem_ack_i = 1'($urandom);
            done_i    = 1'($urandom);
            new_pc_i  = ADDR_W'($urandom);
            tick();
            check_outputs(tag, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; en_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
        done_i = 1'b0; new_pc_i = '0;
        m_pc = '0; m_ir = '0; m_cnt = '0; m_err = 1'b0;
        #2;
        check_outputs("por", 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check_outputs("idle0", 1'b0, 1'b0);

        // First fetch at 0x00, ack on the first request cycle.
        start_fetch("t1.start");
        do_fetch("t1", 0, 16'h1234);
        check_val("t1.instr_direct", 32'(instruction_o), 32'h1234);

        // Sequential and branch retirements, including 0xFF -> 0x00.
        do_exec("t2a", 0, 1'b1, 8'h05);
        do_fetch("t2b", 1, 16'hBEEF);
        do_exec("t2c", 2, 1'b1, 8'h06);
        check_val("t2.addr_direct", 32'(mem_addr_o), 32'h06);
        do_fetch("t3a", 0, 16'h0F0F);
        do_exec("t3b", 0, 1'b1, 8'h20);
        do_fetch("t3c", 2, 16'hA5A5);
        do_exec("t3d", 1, 1'b1, 8'hFF);
        do_fetch("t3e", 0, 16'h5A5A);
        do_exec("t3f", 0, 1'b1, 8'h00);

        // Ack on the last allowed cycle: no error.
        do_fetch("t4a", TIMEOUT - 1, 16'h7777);
        // Wait 4, then en_i dropped in EXEC: IDLE after done, no further fetch.
        do_exec("t5a", 0, 1'b1, 8'h40);
        do_fetch("t5b", 4, 16'h1111);
        do_exec("t5c", 3, 1'b0, 8'h41);
        idle_noise("t5d", 4);

        // Timeout parks in IDLE with the error set, even with en_i high.
        start_fetch("t4b.start");
        do_timeout("t4b");

        // Reset while requesting and while executing.
        do_reset("t6a");
        start_fetch("t6b.start");
        en_i = 1'b1; mem_ack_i = 1'b0;
        tick();
        check_outputs("t6b.wait", 1'b1, 1'b0);
        do_reset("t6b");
        start_fetch("t6c.start");
        do_fetch("t6c", 1, 16'hCAFE);
        do_reset("t6c.rst");

        // Randomized instruction streams.
        start_fetch("rnd.start");
        for (int it = 0; it < 200; it++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                do_timeout("rnd.tmo");
                do_reset("rnd.tmo_rst");
                start_fetch("rnd.restart");
            end else begin
                logic en_after;
                do_fetch("rnd.f", int'($urandom_range(0, TIMEOUT - 1)), INSTR_W'($urandom));
                if (sel == 1) begin
                    do_reset("rnd.exec_rst");
                    start_fetch("rnd.restart2");
                end else begin
                    en_after = ($urandom_range(0, 3) != 0);
                    do_exec("rnd.x", int'($urandom_range(0, 3)), en_after, ADDR_W'($urandom));
                    if (!en_after) begin
                        idle_noise("rnd.idle", int'($urandom_range(0, 3)));
                        start_fetch("rnd.resume");
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
